dmux_stream_router: RTL



---
 rtl/dmux_stream_router_pkg.sv | 12 +
 rtl/dmux_stream_router_if.sv | 42 ++++
 rtl/dmux_stream_router_fifo.sv | 64 ++++++
 rtl/dmux_stream_router.sv | 76 +++++++
 4 files changed

// File: rtl/dmux_stream_router_pkg.sv
// Shared channel-select encoding and sizing helper for the stream router slice.
package dmux_router_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Occupancy must be able to hold the value DEPTH itself, hence the extra bit.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dmux_stream_router_if.sv
// Handshake bundle for dmux_stream_router; in_bcast exists only with DMUX_ROUTER_BCAST_EN.
interface dmux_stream_router_if
   import dmux_router_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CW = count_width(DEPTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
`ifdef DMUX_ROUTER_BCAST_EN
   logic             in_bcast;
`endif
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic [CW-1:0]    a_count;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
   logic [CW-1:0]    b_count;

   modport master (
`ifdef DMUX_ROUTER_BCAST_EN
      output in_bcast,
`endif
      output in_valid, in_data, in_sel, a_ready, b_ready,
      input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
   );

   modport slave (
`ifdef DMUX_ROUTER_BCAST_EN
      input  in_bcast,
`endif
      input  in_valid, in_data, in_sel, a_ready, b_ready,
      output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
   );

endinterface

// File: rtl/dmux_stream_router_fifo.sv
// Per-channel FIFO: power-of-two depth, wrapping pointers, registered occupancy.
module dmux_router_fifo
   import dmux_router_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_next_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == CW'(0));
   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

   // Qualify requests and compute next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      do_push_s    = push & ~full;
      do_pop_s     = pop & ~empty;
      count_next_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         count_r <= count_next_s;
      end
   end

   // Storage array; contents are don't-care while empty, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= wdata;
   end

endmodule

// File: rtl/dmux_stream_router.sv
// Buffered 1:2 stream demultiplexer (sel 0 -> A, 1 -> B) with per-channel FIFOs.
// Optional broadcast to both channels when DMUX_ROUTER_BCAST_EN is defined.
module dmux_stream_router
   import dmux_router_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   dmux_stream_router_if.slave bus
);

   localparam int CW = count_width(DEPTH);

   logic             a_full_s, b_full_s, a_empty_s, b_empty_s;
   logic             bcast_s, ready_s, accept_s, push_a_s, push_b_s;
   logic [CW-1:0]    a_count_s, b_count_s;
   logic [WIDTH-1:0] a_head_s, b_head_s;

   // Ready uses registered fullness only, so a same-cycle pop never frees a slot for this push.
   always_comb begin
      bcast_s = 1'b0;
`ifdef DMUX_ROUTER_BCAST_EN
      bcast_s = bus.in_bcast;
`endif
      if (bcast_s) begin
         ready_s = ~a_full_s & ~b_full_s;
      end else if (bus.in_sel == SEL_B) begin
         ready_s = ~b_full_s;
      end else begin
         ready_s = ~a_full_s;
      end
      accept_s = bus.in_valid & ready_s;
      if (bcast_s) begin
         push_a_s = accept_s;
         push_b_s = accept_s;
      end else begin
         push_a_s = accept_s & (bus.in_sel == SEL_A);
         push_b_s = accept_s & (bus.in_sel == SEL_B);
      end
   end

   dmux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .reset (reset),
      .push  (push_a_s),
      .pop   (bus.a_ready),
      .wdata (bus.in_data),
      .full  (a_full_s),
      .empty (a_empty_s),
      .count (a_count_s),
      .head  (a_head_s)
   );

   dmux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .reset (reset),
      .push  (push_b_s),
      .pop   (bus.b_ready),
      .wdata (bus.in_data),
      .full  (b_full_s),
      .empty (b_empty_s),
      .count (b_count_s),
      .head  (b_head_s)
   );

   assign bus.in_ready = ready_s;
   assign bus.a_valid  = ~a_empty_s;
   assign bus.a_data   = a_head_s;
   assign bus.a_count  = a_count_s;
   assign bus.b_valid  = ~b_empty_s;
   assign bus.b_data   = b_head_s;
   assign bus.b_count  = b_count_s;

endmodule
